axi_lite_a32_d32_master_buf: RTL and testbench

Master-side counterpart of the AXI-Lite (32-bit address, 32-bit data) logic-link adapter. It accepts AXI-Lite requests from a user master, buffers each channel in a two-entry skid buffer, and packs AR/AW/W into the TX logic-link FIFOs. It unpacks R/B from the RX FIFOs back to the master, and limits outstanding reads and writes to a configurable credit count.

---
 rtl/axi_lite_a32_d32_pkg.sv | 30 +++
 rtl/axi_lite_skid2.sv | 81 ++++++++
 rtl/axi_lite_a32_d32_master_buf.sv | 240 ++++++++++++++++++++++++
 tb/tb_axi_lite_a32_d32_master_buf.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_a32_d32_pkg.sv
// -----------------------------------------------------------------------------
// axi_lite_a32_d32_pkg
// Shared definitions for the AXI-Lite (32-bit address, 32-bit data) logic-link
// adapter. It holds:
//   - the packed widths of each link channel;
//   - the AXI response encodings;
//   - a helper that packs a W beat into its link word.
// -----------------------------------------------------------------------------
package axi_lite_a32_d32_pkg;

    localparam int AR_LITE_W = 32;  // {araddr}
    localparam int AW_LITE_W = 32;  // {awaddr}
    localparam int W_LITE_W  = 36;  // {wstrb, wdata}
    localparam int R_LITE_W  = 34;  // {rresp, rdata}
    localparam int B_LITE_W  = 2;   // {bresp}

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    // Pack a write beat as {strobes, data}, strobes in the top nibble.
    function automatic logic [W_LITE_W-1:0] pack_w(input logic [3:0]  strb,
                                                   input logic [31:0] data);
        return {strb, data};
    endfunction

endpackage

// File: rtl/axi_lite_skid2.sv
// -----------------------------------------------------------------------------
// axi_lite_skid2
// Two-entry valid/ready skid buffer for one channel.
//   clk       : clock
//   rst       : synchronous active-high reset, empties the buffer
//   in_valid  : upstream beat valid
//   in_ready  : registered "not full"; 0 during reset
//   in_data   : upstream beat payload
//   out_valid : "not empty"
//   out_ready : downstream accept
//   out_data  : head entry
// A beat accepted at edge N is visible on the output after that edge.
// -----------------------------------------------------------------------------
module axi_lite_skid2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [1:0]       count_r;
    logic [1:0]       count_next_s;
    logic             ready_r;
    logic [WIDTH-1:0] head_r;
    logic [WIDTH-1:0] tail_r;
    logic             push_s;
    logic             pop_s;

    assign push_s    = in_valid & ready_r;
    assign pop_s     = (count_r != 2'd0) & out_ready;
    assign in_ready  = ready_r;
    assign out_valid = (count_r != 2'd0);
    assign out_data  = head_r;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + 2'd1;
            2'b01:   count_next_s = count_r - 2'd1;
            default: count_next_s = count_r;
        endcase
    end

    // Occupancy, ready and storage. The head always holds the oldest beat;
    // the tail is only meaningful when both entries are in use.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= 2'd0;
            ready_r <= 1'b0;
            head_r  <= {WIDTH{1'b0}};
            tail_r  <= {WIDTH{1'b0}};
        end else begin
            count_r <= count_next_s;
            ready_r <= (count_next_s != 2'd2);
            if (push_s && pop_s) begin
                if (count_r == 2'd2) begin
                    head_r <= tail_r;
                    tail_r <= in_data;
                end else begin
                    head_r <= in_data;
                end
            end else if (push_s) begin
                if (count_r == 2'd0) begin
                    head_r <= in_data;
                end else begin
                    tail_r <= in_data;
                end
            end else if (pop_s && (count_r == 2'd2)) begin
                head_r <= tail_r;
            end
        end
    end

endmodule

// File: rtl/axi_lite_a32_d32_master_buf.sv
// -----------------------------------------------------------------------------
// axi_lite_a32_d32_master_buf
// Master-side AXI-Lite (A32/D32) logic-link adapter.
// - AR/AW/W from the user master are buffered and handed to the TX link FIFOs.
// - R/B from the RX link FIFOs are buffered and returned to the master.
// - Reads and writes awaiting a response are each limited to MAX_OUTSTANDING.
//
// Ports:
//   clk_wr, rst_wr          clock, synchronous active-high reset
//   user_ar*/aw*/w*         request channels from the master
//   user_r*/b*              response channels to the master
//   user_*_lite_vld/ready   link-side handshakes
//   txfifo_*/rxfifo_*       packed link words
//   m_gen2_mode             unused here
//   rd_/wr_outstanding      registered outstanding counts
//   orphan_err              sticky orphan-response flag
//
// Build option AXI_LITE_M_ORPHAN_CHECK_EN:
//   defined   - a response arriving with nothing owed is accepted, dropped,
//               and sets orphan_err;
//   undefined - such a response passes through, the counter holds at 0,
//               and orphan_err stays 0.
// -----------------------------------------------------------------------------
module axi_lite_a32_d32_master_buf
    import axi_lite_a32_d32_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                 clk_wr,
    input  logic                 rst_wr,
    input  logic [31:0]          user_araddr,
    input  logic                 user_arvalid,
    output logic                 user_arready,
    input  logic [31:0]          user_awaddr,
    input  logic                 user_awvalid,
    output logic                 user_awready,
    input  logic [31:0]          user_wdata,
    input  logic [3:0]           user_wstrb,
    input  logic                 user_wvalid,
    output logic                 user_wready,
    output logic [31:0]          user_rdata,
    output logic [1:0]           user_rresp,
    output logic                 user_rvalid,
    input  logic                 user_rready,
    output logic [1:0]           user_bresp,
    output logic                 user_bvalid,
    input  logic                 user_bready,
    output logic                 user_ar_lite_vld,
    output logic [AR_LITE_W-1:0] txfifo_ar_lite_data,
    input  logic                 user_ar_lite_ready,
    output logic                 user_aw_lite_vld,
    output logic [AW_LITE_W-1:0] txfifo_aw_lite_data,
    input  logic                 user_aw_lite_ready,
    output logic                 user_w_lite_vld,
    output logic [W_LITE_W-1:0]  txfifo_w_lite_data,
    input  logic                 user_w_lite_ready,
    input  logic                 user_r_lite_vld,
    input  logic [R_LITE_W-1:0]  rxfifo_r_lite_data,
    output logic                 user_r_lite_ready,
    input  logic                 user_b_lite_vld,
    input  logic [B_LITE_W-1:0]  rxfifo_b_lite_data,
    output logic                 user_b_lite_ready,
    input  logic                 m_gen2_mode,
    output logic [CNT_W-1:0]     rd_outstanding,
    output logic [CNT_W-1:0]     wr_outstanding,
    output logic                 orphan_err
);

    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0]    rd_cnt_r;
    logic [CNT_W-1:0]    wr_cnt_r;
    logic [CNT_W-1:0]    rd_cnt_next_s;
    logic [CNT_W-1:0]    wr_cnt_next_s;
    logic                ar_credit_s;
    logic                aw_credit_s;
    logic                ar_in_ready_s;
    logic                aw_in_ready_s;
    logic                r_in_valid_s;
    logic                b_in_valid_s;
    logic                r_in_ready_s;
    logic                b_in_ready_s;
    logic                r_owed_s;
    logic                b_owed_s;
    logic                r_drop_s;
    logic                b_drop_s;
    logic                rd_inc_s;
    logic                rd_dec_s;
    logic                wr_inc_s;
    logic                wr_dec_s;
    logic [R_LITE_W-1:0] r_out_data_s;
    logic                unused_s;

    assign unused_s = m_gen2_mode;

    // Credit gating uses the registered counts only.
    assign ar_credit_s  = (rd_cnt_r < MAX_CNT);
    assign aw_credit_s  = (wr_cnt_r < MAX_CNT);
    assign user_arready = ar_in_ready_s & ar_credit_s;
    assign user_awready = aw_in_ready_s & aw_credit_s;

    assign r_owed_s = (rd_cnt_r != CNT_ZERO);
    assign b_owed_s = (wr_cnt_r != CNT_ZERO);

`ifdef AXI_LITE_M_ORPHAN_CHECK_EN
    logic run_r;
    logic orphan_err_r;

    // Keeps the forced orphan-accept from driving ready high during reset.
    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            run_r <= 1'b0;
        end else begin
            run_r <= 1'b1;
        end
    end

    assign r_drop_s = user_r_lite_vld & ~r_owed_s & run_r;
    assign b_drop_s = user_b_lite_vld & ~b_owed_s & run_r;

    // Sticky orphan flag, cleared only by reset.
    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            orphan_err_r <= 1'b0;
        end else begin
            orphan_err_r <= orphan_err_r | r_drop_s | b_drop_s;
        end
    end

    assign orphan_err = orphan_err_r;
`else
    assign r_drop_s   = 1'b0;
    assign b_drop_s   = 1'b0;
    assign orphan_err = 1'b0;
`endif

    // A dropped orphan beat is acknowledged without entering the buffer.
    assign r_in_valid_s      = user_r_lite_vld & ~r_drop_s;
    assign b_in_valid_s      = user_b_lite_vld & ~b_drop_s;
    assign user_r_lite_ready = r_in_ready_s | r_drop_s;
    assign user_b_lite_ready = b_in_ready_s | b_drop_s;

    assign rd_inc_s = user_arvalid & user_arready;
    assign wr_inc_s = user_awvalid & user_awready;
    // Decrement only when something is owed, so the count never wraps below 0.
    assign rd_dec_s = r_in_valid_s & r_in_ready_s & r_owed_s;
    assign wr_dec_s = b_in_valid_s & b_in_ready_s & b_owed_s;

    // Next outstanding counts; simultaneous inc and dec cancel.
    always_comb begin
        rd_cnt_next_s = rd_cnt_r;
        wr_cnt_next_s = wr_cnt_r;
        case ({rd_inc_s, rd_dec_s})
            2'b10:   rd_cnt_next_s = rd_cnt_r + CNT_ONE;
            2'b01:   rd_cnt_next_s = rd_cnt_r - CNT_ONE;
            default: rd_cnt_next_s = rd_cnt_r;
        endcase
        case ({wr_inc_s, wr_dec_s})
            2'b10:   wr_cnt_next_s = wr_cnt_r + CNT_ONE;
            2'b01:   wr_cnt_next_s = wr_cnt_r - CNT_ONE;
            default: wr_cnt_next_s = wr_cnt_r;
        endcase
    end

    // Outstanding counters.
    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            rd_cnt_r <= CNT_ZERO;
            wr_cnt_r <= CNT_ZERO;
        end else begin
            rd_cnt_r <= rd_cnt_next_s;
            wr_cnt_r <= wr_cnt_next_s;
        end
    end

    assign rd_outstanding = rd_cnt_r;
    assign wr_outstanding = wr_cnt_r;

    axi_lite_skid2 #(.WIDTH(AR_LITE_W)) u_ar_buf (
        .clk       (clk_wr),
        .rst       (rst_wr),
        .in_valid  (user_arvalid & ar_credit_s),
        .in_ready  (ar_in_ready_s),
        .in_data   (user_araddr),
        .out_valid (user_ar_lite_vld),
        .out_ready (user_ar_lite_ready),
        .out_data  (txfifo_ar_lite_data)
    );

    axi_lite_skid2 #(.WIDTH(AW_LITE_W)) u_aw_buf (
        .clk       (clk_wr),
        .rst       (rst_wr),
        .in_valid  (user_awvalid & aw_credit_s),
        .in_ready  (aw_in_ready_s),
        .in_data   (user_awaddr),
        .out_valid (user_aw_lite_vld),
        .out_ready (user_aw_lite_ready),
        .out_data  (txfifo_aw_lite_data)
    );

    axi_lite_skid2 #(.WIDTH(W_LITE_W)) u_w_buf (
        .clk       (clk_wr),
        .rst       (rst_wr),
        .in_valid  (user_wvalid),
        .in_ready  (user_wready),
        .in_data   (pack_w(user_wstrb, user_wdata)),
        .out_valid (user_w_lite_vld),
        .out_ready (user_w_lite_ready),
        .out_data  (txfifo_w_lite_data)
    );

    axi_lite_skid2 #(.WIDTH(R_LITE_W)) u_r_buf (
        .clk       (clk_wr),
        .rst       (rst_wr),
        .in_valid  (r_in_valid_s),
        .in_ready  (r_in_ready_s),
        .in_data   (rxfifo_r_lite_data),
        .out_valid (user_rvalid),
        .out_ready (user_rready),
        .out_data  (r_out_data_s)
    );

    assign user_rresp = r_out_data_s[33:32];
    assign user_rdata = r_out_data_s[31:0];

    axi_lite_skid2 #(.WIDTH(B_LITE_W)) u_b_buf (
        .clk       (clk_wr),
        .rst       (rst_wr),
        .in_valid  (b_in_valid_s),
        .in_ready  (b_in_ready_s),
        .in_data   (rxfifo_b_lite_data),
        .out_valid (user_bvalid),
        .out_ready (user_bready),
        .out_data  (user_bresp)
    );

endmodule

// File: tb/tb_axi_lite_a32_d32_master_buf.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_a32_d32_master_buf
// Directed bench for axi_lite_a32_d32_master_buf with MAX_OUTSTANDING=4.
// Inputs change 1 time unit after the rising edge; outputs are checked there.
// -----------------------------------------------------------------------------
module tb_axi_lite_a32_d32_master_buf;
    import axi_lite_a32_d32_pkg::*;

    localparam int MAXO  = 4;
    localparam int CNT_W = $clog2(MAXO + 1);

    logic              clk_wr = 1'b0;
    logic              rst_wr;
    logic [31:0]       user_araddr;
    logic              user_arvalid;
    logic              user_arready;
    logic [31:0]       user_awaddr;
    logic              user_awvalid;
    logic              user_awready;
    logic [31:0]       user_wdata;
    logic [3:0]        user_wstrb;
    logic              user_wvalid;
    logic              user_wready;
    logic [31:0]       user_rdata;
    logic [1:0]        user_rresp;
    logic              user_rvalid;
    logic              user_rready;
    logic [1:0]        user_bresp;
    logic              user_bvalid;
    logic              user_bready;
    logic              user_ar_lite_vld;
    logic [31:0]       txfifo_ar_lite_data;
    logic              user_ar_lite_ready;
    logic              user_aw_lite_vld;
    logic [31:0]       txfifo_aw_lite_data;
    logic              user_aw_lite_ready;
    logic              user_w_lite_vld;
    logic [35:0]       txfifo_w_lite_data;
    logic              user_w_lite_ready;
    logic              user_r_lite_vld;
    logic [33:0]       rxfifo_r_lite_data;
    logic              user_r_lite_ready;
    logic              user_b_lite_vld;
    logic [1:0]        rxfifo_b_lite_data;
    logic              user_b_lite_ready;
    logic              m_gen2_mode;
    logic [CNT_W-1:0]  rd_outstanding;
    logic [CNT_W-1:0]  wr_outstanding;
    logic              orphan_err;

    int check_cnt = 0;
    int error_cnt = 0;

    axi_lite_a32_d32_master_buf #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk_wr              (clk_wr),
        .rst_wr              (rst_wr),
        .user_araddr         (user_araddr),
        .user_arvalid        (user_arvalid),
        .user_arready        (user_arready),
        .user_awaddr         (user_awaddr),
        .user_awvalid        (user_awvalid),
        .user_awready        (user_awready),
        .user_wdata          (user_wdata),
        .user_wstrb          (user_wstrb),
        .user_wvalid         (user_wvalid),
        .user_wready         (user_wready),
        .user_rdata          (user_rdata),
        .user_rresp          (user_rresp),
        .user_rvalid         (user_rvalid),
        .user_rready         (user_rready),
        .user_bresp          (user_bresp),
        .user_bvalid         (user_bvalid),
        .user_bready         (user_bready),
        .user_ar_lite_vld    (user_ar_lite_vld),
        .txfifo_ar_lite_data (txfifo_ar_lite_data),
        .user_ar_lite_ready  (user_ar_lite_ready),
        .user_aw_lite_vld    (user_aw_lite_vld),
        .txfifo_aw_lite_data (txfifo_aw_lite_data),
        .user_aw_lite_ready  (user_aw_lite_ready),
        .user_w_lite_vld     (user_w_lite_vld),
        .txfifo_w_lite_data  (txfifo_w_lite_data),
        .user_w_lite_ready   (user_w_lite_ready),
        .user_r_lite_vld     (user_r_lite_vld),
        .rxfifo_r_lite_data  (rxfifo_r_lite_data),
        .user_r_lite_ready   (user_r_lite_ready),
        .user_b_lite_vld     (user_b_lite_vld),
        .rxfifo_b_lite_data  (rxfifo_b_lite_data),
        .user_b_lite_ready   (user_b_lite_ready),
        .m_gen2_mode         (m_gen2_mode),
        .rd_outstanding      (rd_outstanding),
        .wr_outstanding      (wr_outstanding),
        .orphan_err          (orphan_err)
    );

    // 10-unit clock.
    always #5 clk_wr = ~clk_wr;

    task automatic tick();
        @(posedge clk_wr);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            error_cnt++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_wr             = 1'b1;
        user_araddr        = 32'h0;
        user_arvalid       = 1'b0;
        user_awaddr        = 32'h0;
        user_awvalid       = 1'b0;
        user_wdata         = 32'h0;
        user_wstrb         = 4'h0;
        user_wvalid        = 1'b0;
        user_rready        = 1'b0;
        user_bready        = 1'b0;
        user_ar_lite_ready = 1'b1;
        user_aw_lite_ready = 1'b1;
        user_w_lite_ready  = 1'b1;
        user_r_lite_vld    = 1'b0;
        rxfifo_r_lite_data = 34'h0;
        user_b_lite_vld    = 1'b0;
        rxfifo_b_lite_data = 2'b00;
        m_gen2_mode        = 1'b0;

        // Reset state.
        tick(); tick(); tick();
        check_val("rst_arready", user_arready, 1'b0);
        check_val("rst_wready", user_wready, 1'b0);
        check_val("rst_r_lite_ready", user_r_lite_ready, 1'b0);
        check_val("rst_ar_vld", user_ar_lite_vld, 1'b0);
        check_val("rst_rd_out", rd_outstanding, 0);
        check_val("rst_orphan", orphan_err, 1'b0);
        rst_wr = 1'b0;
        tick();
        check_val("post_rst_arready", user_arready, 1'b1);
        check_val("post_rst_awready", user_awready, 1'b1);

        // Four back-to-back reads, each visible one cycle after acceptance.
        user_arvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            user_araddr = 32'h1000 + 32'(4 * i);
            check_val("ar_ready_burst", user_arready, 1'b1);
            tick();
            check_val("ar_vld_burst", user_ar_lite_vld, 1'b1);
            check_val("ar_data_burst", txfifo_ar_lite_data, 32'h1000 + 32'(4 * i));
        end
        user_arvalid = 1'b0;
        tick();
        check_val("rd_out_4", rd_outstanding, 4);
        check_val("ar_vld_drained", user_ar_lite_vld, 1'b0);

        // Fifth read is blocked until one response is accepted.
        user_araddr  = 32'h1010;
        user_arvalid = 1'b1;
        check_val("ar_blocked", user_arready, 1'b0);
        tick();
        check_val("ar_still_blocked", user_arready, 1'b0);
        check_val("ar_vld_blocked", user_ar_lite_vld, 1'b0);
        user_r_lite_vld    = 1'b1;
        rxfifo_r_lite_data = {RESP_OKAY, 32'hDEADBEEF};
        check_val("r_link_ready", user_r_lite_ready, 1'b1);
        tick();
        user_r_lite_vld = 1'b0;
        check_val("rvalid", user_rvalid, 1'b1);
        check_val("rdata", user_rdata, 32'hDEADBEEF);
        check_val("rresp", user_rresp, 2'b00);
        check_val("rd_out_3", rd_outstanding, 3);
        check_val("ar_unblocked", user_arready, 1'b1);
        tick();
        user_arvalid = 1'b0;
        check_val("ar5_vld", user_ar_lite_vld, 1'b1);
        check_val("ar5_data", txfifo_ar_lite_data, 32'h1010);
        check_val("rd_out_4b", rd_outstanding, 4);
        check_val("ar_blocked_again", user_arready, 1'b0);
        user_rready = 1'b1;
        tick();
        check_val("r_drained", user_rvalid, 1'b0);

        // Retire the remaining four reads.
        user_r_lite_vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rxfifo_r_lite_data = {RESP_OKAY, 32'h5000 + 32'(i)};
            tick();
        end
        user_r_lite_vld = 1'b0;
        tick();
        check_val("rd_out_0", rd_outstanding, 0);
        check_val("r_idle", user_rvalid, 1'b0);

        // One write with a SLVERR response.
        user_awaddr  = 32'h2000;
        user_awvalid = 1'b1;
        user_wdata   = 32'hA5A5A5A5;
        user_wstrb   = 4'hF;
        user_wvalid  = 1'b1;
        tick();
        user_awvalid = 1'b0;
        user_wvalid  = 1'b0;
        check_val("aw_vld", user_aw_lite_vld, 1'b1);
        check_val("aw_data", txfifo_aw_lite_data, 32'h2000);
        check_val("w_vld", user_w_lite_vld, 1'b1);
        check_val("w_data", txfifo_w_lite_data, 36'hFA5A5A5A5);
        check_val("wr_out_1", wr_outstanding, 1);
        tick();
        user_b_lite_vld    = 1'b1;
        rxfifo_b_lite_data = RESP_SLVERR;
        tick();
        user_b_lite_vld = 1'b0;
        check_val("bvalid", user_bvalid, 1'b1);
        check_val("bresp", user_bresp, 2'b10);
        check_val("wr_out_0", wr_outstanding, 0);
        user_bready = 1'b1;
        tick();
        check_val("b_drained", user_bvalid, 1'b0);

        // W backpressure: two beats absorbed, third refused.
        user_w_lite_ready = 1'b0;
        user_wvalid = 1'b1;
        user_wdata  = 32'h11111111; user_wstrb = 4'h1;
        check_val("w_bp_ready0", user_wready, 1'b1);
        tick();
        user_wdata  = 32'h22222222; user_wstrb = 4'h3;
        check_val("w_bp_ready1", user_wready, 1'b1);
        tick();
        user_wdata  = 32'h33333333; user_wstrb = 4'h7;
        check_val("w_bp_full", user_wready, 1'b0);
        tick();
        user_wvalid = 1'b0;
        check_val("w_bp_still_full", user_wready, 1'b0);
        check_val("w_bp_head", txfifo_w_lite_data, 36'h111111111);
        user_w_lite_ready = 1'b1;
        tick();
        check_val("w_bp_second_vld", user_w_lite_vld, 1'b1);
        check_val("w_bp_second", txfifo_w_lite_data, 36'h322222222);
        check_val("w_bp_ready_back", user_wready, 1'b1);
        tick();
        check_val("w_bp_empty", user_w_lite_vld, 1'b0);

        // Orphan read response with nothing owed.
        user_rready        = 1'b0;
        user_r_lite_vld    = 1'b1;
        rxfifo_r_lite_data = {RESP_EXOKAY, 32'h0BAD0BAD};
        check_val("orphan_link_ready", user_r_lite_ready, 1'b1);
        tick();
        user_r_lite_vld = 1'b0;
`ifdef AXI_LITE_M_ORPHAN_CHECK_EN
        check_val("orphan_dropped", user_rvalid, 1'b0);
        check_val("orphan_err_set", orphan_err, 1'b1);
`else
        check_val("orphan_passed", user_rvalid, 1'b1);
        check_val("orphan_rdata", user_rdata, 32'h0BAD0BAD);
        check_val("orphan_err_tied", orphan_err, 1'b0);
`endif
        check_val("orphan_rd_out", rd_outstanding, 0);
        user_rready = 1'b1;
        tick();

        // Reset with data parked in the AR and W buffers.
        user_ar_lite_ready = 1'b0;
        user_w_lite_ready  = 1'b0;
        user_arvalid = 1'b1; user_araddr = 32'h3000;
        user_wvalid  = 1'b1; user_wdata  = 32'h77777777; user_wstrb = 4'hF;
        tick();
        user_araddr = 32'h3004;
        user_wvalid = 1'b0;
        tick();
        user_arvalid = 1'b0;
        check_val("pre_rst_ar_vld", user_ar_lite_vld, 1'b1);
        check_val("pre_rst_w_vld", user_w_lite_vld, 1'b1);
        check_val("pre_rst_rd_out", rd_outstanding, 2);
        rst_wr = 1'b1;
        tick();
        check_val("in_rst_ar_vld", user_ar_lite_vld, 1'b0);
        check_val("in_rst_w_vld", user_w_lite_vld, 1'b0);
        check_val("in_rst_rvalid", user_rvalid, 1'b0);
        check_val("in_rst_bvalid", user_bvalid, 1'b0);
        check_val("in_rst_arready", user_arready, 1'b0);
        check_val("in_rst_awready", user_awready, 1'b0);
        check_val("in_rst_wready", user_wready, 1'b0);
        check_val("in_rst_r_lite_ready", user_r_lite_ready, 1'b0);
        check_val("in_rst_b_lite_ready", user_b_lite_ready, 1'b0);
        check_val("in_rst_rd_out", rd_outstanding, 0);
        check_val("in_rst_wr_out", wr_outstanding, 0);
        check_val("in_rst_orphan", orphan_err, 1'b0);
        tick();
        rst_wr = 1'b0;
        user_ar_lite_ready = 1'b1;
        user_w_lite_ready  = 1'b1;
        tick();
        check_val("after_rst_arready", user_arready, 1'b1);
        check_val("after_rst_ar_vld", user_ar_lite_vld, 1'b0);
        tick();
        check_val("no_stale_ar", user_ar_lite_vld, 1'b0);
        check_val("no_stale_w", user_w_lite_vld, 1'b0);

        $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
        $finish;
    end

endmodule
